pc_fetch_ctrl: RTL and testbench

- Program-counter and fetch-control stage directly upstream of the ALU.
- Owns the PC register and drives the instruction-memory request.
- Decodes the fetched instruction's opcode, condition code and offset, and evaluates B/BR against the registered N/Z/V flags the ALU produces.
- Handles HLT and instruction-memory wait timeouts; supplies PC+2 for PCS writeback.

---
 rtl/pc_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter, instruction fetch, branch resolution, halt and fetch timeout
module pc_fetch_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          TIMEOUT  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        N_Flag,
   input  logic        Z_Flag,
   input  logic        V_Flag,
   input  logic [15:0] reg_target,
   output logic [15:0] imem_addr,
   output logic        imem_req,
   output logic [15:0] pc,
   output logic [15:0] pc_plus2,
   output logic        instr_valid,
   output logic        branch_taken,
   output logic        halted,
   output logic        fetch_err
);
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   state_t      r_state, w_state_nx;
   logic [15:0] r_pc, w_pc_nx, w_pc_plus2, w_b_target;
   logic [7:0]  r_cnt, w_cnt_nx;
   logic        r_bt, w_bt_nx, r_err, w_err_nx;
   logic [3:0]  w_op;
   logic [2:0]  w_ccc;
   logic [8:0]  w_imm9;
   logic        w_cond, w_accept;
   assign w_op       = instr[15:12];
   assign w_ccc      = instr[11:9];
   assign w_imm9     = instr[8:0];
   assign w_pc_plus2 = r_pc + 16'd2;
   assign w_b_target = w_pc_plus2 + {{6{w_imm9[8]}}, w_imm9, 1'b0};
   assign w_accept   = (r_state == S_FETCH) & imem_ready & ~stall;
   assign imem_addr    = r_pc;
   assign pc           = r_pc;
   assign pc_plus2     = w_pc_plus2;
   assign imem_req     = (r_state == S_FETCH);
   assign instr_valid  = w_accept;
   assign halted       = (r_state == S_HALT);
   assign branch_taken = r_bt;
   assign fetch_err    = r_err;
   // branch condition from the registered ALU flags, no forwarding
   always_comb begin
      w_cond = 1'b1;
      case (w_ccc)
         3'b000:  w_cond = ~Z_Flag;
         3'b001:  w_cond = Z_Flag;
         3'b010:  w_cond = ~Z_Flag & ~N_Flag;
         3'b011:  w_cond = N_Flag;
         3'b100:  w_cond = Z_Flag | (~Z_Flag & ~N_Flag);
         3'b101:  w_cond = N_Flag | Z_Flag;
         3'b110:  w_cond = V_Flag;
         default: w_cond = 1'b1;
      endcase
   end
   // next state, next pc, wait counter and sticky error
   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      w_cnt_nx   = r_cnt;
      w_bt_nx    = r_bt;
      w_err_nx   = r_err;
      case (r_state)
         S_IDLE:  w_state_nx = S_FETCH;
         S_FETCH: begin
            if (!imem_ready) begin
               w_cnt_nx = r_cnt + 8'd1;
               if (r_cnt == TO_LAST) begin
                  w_err_nx   = 1'b1;
                  w_state_nx = S_HALT;
               end
            end else begin
               w_cnt_nx = 8'd0;
               if (!stall) begin
                  if (w_op == 4'b1111) begin
                     w_state_nx = S_HALT;
                     w_bt_nx    = 1'b0;
                  end else if (w_op == 4'b1100 && w_cond) begin
                     w_pc_nx = w_b_target;
                     w_bt_nx = 1'b1;
                  end else if (w_op == 4'b1101 && w_cond) begin
                     w_pc_nx = reg_target;
                     w_bt_nx = 1'b1;
                  end else begin
                     w_pc_nx = w_pc_plus2;
                     w_bt_nx = 1'b0;
                  end
               end
            end
         end
         default: w_state_nx = S_HALT;
      endcase
   end
   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_cnt   <= 8'd0;
         r_bt    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_pc    <= w_pc_nx;
         r_cnt   <= w_cnt_nx;
         r_bt    <= w_bt_nx;
         r_err   <= w_err_nx;
      end
   end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and random checks of pc_fetch_ctrl against a behavioural model
module tb_pc_fetch_ctrl;
   localparam int TIMEOUT = 8;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] instr = 16'h0000;
   logic        imem_ready = 1'b0;
   logic        stall = 1'b0;
   logic        N_Flag = 1'b0, Z_Flag = 1'b0, V_Flag = 1'b0;
   logic [15:0] reg_target = 16'h0000;
   logic [15:0] imem_addr, pc, pc_plus2;
   logic        imem_req, instr_valid, branch_taken, halted, fetch_err;
   int total = 0;
   int bad = 0;
   int m_pc, m_ph, m_wait;
   bit m_bt, m_err, m_known;

   pc_fetch_ctrl #(.RESET_PC(16'h0000), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready), .stall(stall),
      .N_Flag(N_Flag), .Z_Flag(Z_Flag), .V_Flag(V_Flag), .reg_target(reg_target),
      .imem_addr(imem_addr), .imem_req(imem_req), .pc(pc), .pc_plus2(pc_plus2),
      .instr_valid(instr_valid), .branch_taken(branch_taken), .halted(halted),
      .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // phases: 0 idle, 1 fetching, 2 halted
   function automatic void model_step();
      logic [7:0] truth;
      int imm;
      if (rst) begin
         m_pc = 0; m_ph = 0; m_wait = 0; m_bt = 0; m_err = 0; m_known = 1;
      end else if (m_ph == 0) begin
         m_ph = 1;
      end else if (m_ph == 1) begin
         if (!imem_ready) begin
            m_wait++;
            if (m_wait >= TIMEOUT) begin m_err = 1; m_ph = 2; end
         end else begin
            m_wait = 0;
            if (!stall) begin
               truth = {1'b1, V_Flag, N_Flag | Z_Flag, Z_Flag | !N_Flag, N_Flag,
                        !Z_Flag & !N_Flag, Z_Flag, !Z_Flag};
               imm = instr[8] ? int'(instr[8:0]) - 512 : int'(instr[8:0]);
               if (instr[15:12] == 4'hF) begin m_ph = 2; m_bt = 0; end
               else if (instr[15:12] == 4'hC && truth[instr[11:9]]) begin
                  m_pc = (m_pc + 2 + 2 * imm) & 65535; m_bt = 1;
               end else if (instr[15:12] == 4'hD && truth[instr[11:9]]) begin
                  m_pc = int'(reg_target); m_bt = 1;
               end else begin
                  m_pc = (m_pc + 2) & 65535; m_bt = 0;
               end
            end
         end
      end
   endfunction

   task automatic cyc();
      @(negedge clk);
      if (m_known) begin
         chk("imem_req", 16'(imem_req), 16'(m_ph == 1));
         chk("instr_valid", 16'(instr_valid), 16'(m_ph == 1 && imem_ready && !stall));
      end
      @(posedge clk);
      model_step();
      #1;
      chk("pc", pc, 16'(m_pc));
      chk("imem_addr", imem_addr, 16'(m_pc));
      chk("pc_plus2", pc_plus2, 16'((m_pc + 2) & 65535));
      chk("branch_taken", 16'(branch_taken), 16'(m_bt));
      chk("halted", 16'(halted), 16'(m_ph == 2));
      chk("fetch_err", 16'(fetch_err), 16'(m_err));
   endtask

   task automatic go_to(input logic [15:0] target);
      instr = 16'hDE00; reg_target = target; imem_ready = 1; stall = 0;
      cyc();
   endtask

   initial begin
      rst = 1; cyc();
      chk("reset_pc", pc, 16'h0000);
      rst = 0; imem_ready = 1; instr = 16'h0123;
      repeat (4) cyc();
      chk("seq_pc", pc, 16'h0006);
      go_to(16'h0010);
      instr = 16'hC3FC; Z_Flag = 1; cyc();
      chk("b_eq_taken_pc", pc, 16'h000A);
      go_to(16'h0010);
      instr = 16'hC3FC; Z_Flag = 0; cyc();
      chk("b_eq_not_taken_pc", pc, 16'h0012);
      instr = 16'hDE00; reg_target = 16'h1234; cyc();
      chk("br_pc", pc, 16'h1234);
      go_to(16'hFFFE);
      instr = 16'h0000; cyc();
      chk("wrap_pc", pc, 16'h0000);
      stall = 1; repeat (3) cyc();
      stall = 0; imem_ready = 0; repeat (TIMEOUT - 1) cyc();
      imem_ready = 1; cyc();
      chk("wait_pc", pc, 16'h0002);
      imem_ready = 0; repeat (TIMEOUT) cyc();
      chk("timeout_err", 16'(fetch_err), 16'h0001);
      repeat (2) cyc();
      rst = 1; cyc();
      rst = 0; imem_ready = 1; instr = 16'h0123; repeat (2) cyc();
      go_to(16'h0020);
      instr = 16'hF000; repeat (10) cyc();
      chk("hlt_pc", pc, 16'h0020);
      rst = 1; cyc();
      rst = 0;
      repeat (400) begin
         instr = 16'($urandom);
         if (instr[15:12] == 4'hF && $urandom_range(0, 9) != 0) instr[15:12] = 4'h0;
         reg_target = 16'($urandom);
         {N_Flag, Z_Flag, V_Flag} = 3'($urandom);
         imem_ready = $urandom_range(0, 99) < 85;
         stall = $urandom_range(0, 99) < 20;
         rst = $urandom_range(0, 99) < 3;
         cyc();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
